// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

   // Controller states: sequential clear sweep, then normal operation
   typedef enum logic {StClear, StReady} rf_state_e;

   // Default geometry
   localparam int unsigned DataWDef   = 64;
   localparam int unsigned NumRegsDef = 32;
   localparam int unsigned NumRdDef   = 2;
   localparam int unsigned NumWrDef   = 2;

   // Widest packed bus / port slice the helper handles
   localparam int unsigned MaxBusW   = 1024;
   localparam int unsigned MaxSliceW = 128;

   typedef logic [MaxBusW-1:0]   bus_t;
   typedef logic [MaxSliceW-1:0] slice_t;

   // Extract port idx (w bits wide) from a packed, zero-extended bus
   function automatic slice_t get_slice(input bus_t bus, input int unsigned idx,
                                        input int unsigned w);
      bus_t mask;
      mask = (bus_t'(1) << w) - bus_t'(1);
      return slice_t'((bus >> (idx * w)) & mask);
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// Read/write port bundle of the multi-port register file.
interface reg_file_if
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DataWDef,
   parameter int unsigned NUM_REGS = NumRegsDef,
   parameter int unsigned NUM_RD   = NumRdDef,
   parameter int unsigned NUM_WR   = NumWrDef,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) ();

   logic                       ready;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_WR-1:0]          wr_en;
   logic [NUM_WR*ADDR_W-1:0]   wr_addr;
   logic [NUM_WR*DATA_W-1:0]   wr_data;
   logic                       wr_collide;

   // Requester side (decode/writeback logic, testbench)
   modport master (
      input  ready, rd_data, wr_collide,
      output rd_addr, wr_en, wr_addr, wr_data
   );

   // Register file side
   modport slave (
      output ready, rd_data, wr_collide,
      input  rd_addr, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/reg_file_wr_arb.sv
// Write-port arbitration: highest port index wins an address; address 0 never writes.
module reg_file_wr_arb
   import reg_file_pkg::*;
#(
   parameter int unsigned NUM_WR = NumWrDef,
   parameter int unsigned ADDR_W = 5
) (
   input  logic [NUM_WR-1:0]        en_i,
   input  logic [NUM_WR*ADDR_W-1:0] addr_i,
   output logic [NUM_WR-1:0]        eff_en_o,
   output logic                     collide_o
);

   logic [ADDR_W-1:0] addr [NUM_WR];

   // Unpack per-port addresses
   always_comb begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         addr[p] = ADDR_W'(get_slice(bus_t'(addr_i), p, ADDR_W));
      end
   end

   // Mask a port when any higher-indexed enabled port targets the same nonzero address
   always_comb begin
      eff_en_o  = '0;
      collide_o = 1'b0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         eff_en_o[p] = en_i[p] && (addr[p] != '0);
         for (int unsigned q = p + 1; q < NUM_WR; q++) begin
            if (en_i[p] && en_i[q] && (addr[p] != '0) && (addr[q] == addr[p])) begin
               eff_en_o[p] = 1'b0;
               collide_o   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with post-reset clear sweep; entry 0 reads zero.
// Optional RF_BYPASS_EN: same-cycle write data is forwarded to matching reads.
// Port widths must not exceed reg_file_pkg::MaxSliceW / MaxBusW.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DataWDef,
   parameter int unsigned NUM_REGS = NumRegsDef,
   parameter int unsigned NUM_RD   = NumRdDef,
   parameter int unsigned NUM_WR   = NumWrDef,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic      clk,
   input  logic      rst,
   reg_file_if.slave bus_io
);

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              collide_q, collide_d;
   logic [DATA_W-1:0] mem_q [NUM_REGS];

   logic [ADDR_W-1:0] wr_addr [NUM_WR];
   logic [DATA_W-1:0] wr_data [NUM_WR];
   logic [ADDR_W-1:0] rd_addr [NUM_RD];
   logic [NUM_WR-1:0] eff_en;
   logic              collide;
   logic [NUM_RD*DATA_W-1:0] rd_data;

   // Unpack the packed port buses
   always_comb begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         wr_addr[p] = ADDR_W'(get_slice(bus_t'(bus_io.wr_addr), p, ADDR_W));
         wr_data[p] = DATA_W'(get_slice(bus_t'(bus_io.wr_data), p, DATA_W));
      end
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         rd_addr[r] = ADDR_W'(get_slice(bus_t'(bus_io.rd_addr), r, ADDR_W));
      end
   end

   reg_file_wr_arb #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W)
   ) u_wr_arb (
      .en_i      (bus_io.wr_en),
      .addr_i    (bus_io.wr_addr),
      .eff_en_o  (eff_en),
      .collide_o (collide)
   );

   // Next state: sweep walks entries 1..NUM_REGS-1, then accepts writes
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      collide_d = 1'b0;
      unique case (state_q)
         StClear: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(NUM_REGS - 1)) begin
               state_d = StReady;
            end
         end
         StReady: collide_d = collide;
         default: state_d = StClear;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StClear;
         ptr_q     <= ADDR_W'(1);
         collide_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         collide_q <= collide_d;
      end
   end

   // Storage: sweep clears one entry per edge; in READY commit arbitrated writes.
   // No bulk reset so reset fan-out stays independent of depth.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == StClear) begin
            mem_q[ptr_q] <= '0;
         end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
               if (eff_en[p]) begin
                  mem_q[wr_addr[p]] <= wr_data[p];
               end
            end
         end
      end
   end

   // Combinational reads; eff_en is one-hot per address so any bypass match is the winner
   always_comb begin
      rd_data = '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         if (!rst && (state_q == StReady) && (rd_addr[r] != '0)) begin
            rd_data[r*DATA_W +: DATA_W] = mem_q[rd_addr[r]];
`ifdef RF_BYPASS_EN
            for (int unsigned p = 0; p < NUM_WR; p++) begin
               if (eff_en[p] && (wr_addr[p] == rd_addr[r])) begin
                  rd_data[r*DATA_W +: DATA_W] = wr_data[p];
               end
            end
`else
`endif
         end
      end
   end

   assign bus_io.rd_data    = rd_data;
   assign bus_io.ready      = (state_q == StReady);
   assign bus_io.wr_collide = collide_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: scoreboarded default instance plus a wide-port instance.
module tb_reg_file_mp;
   import reg_file_pkg::*;

   localparam int unsigned DW    = 64;
   localparam int unsigned NR    = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
   localparam int unsigned AW    = 5;
   localparam int unsigned NR_B  = 64;
   localparam int unsigned NRD_B = 4;
   localparam int unsigned NWR_B = 3;
   localparam int unsigned AW_B  = 6;

   logic clk = 1'b0;
   logic rst;
   logic rst_b;
   always #5 clk = ~clk;

   reg_file_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus_a ();
   reg_file_if #(.DATA_W(DW), .NUM_REGS(NR_B), .NUM_RD(NRD_B), .NUM_WR(NWR_B)) bus_b ();

   reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut_a (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus_a)
   );

   reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR_B), .NUM_RD(NRD_B), .NUM_WR(NWR_B)) dut_b (
      .clk    (clk),
      .rst    (rst_b),
      .bus_io (bus_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Stimulus for instance A (arrays, packed onto the bus by step)
   logic [NWR-1:0] s_we;
   logic [AW-1:0]  s_wa [NWR];
   logic [DW-1:0]  s_wd [NWR];
   logic [AW-1:0]  s_ra [NRD];

   // Reference model: register contents, sweep progress, pending collide pulse
   logic [DW-1:0] m_mem [NR];
   int unsigned   m_clr_cnt;
   bit            m_ready;
   bit            m_collide;

   typedef struct {
      logic              ready;
      logic              collide;
      logic [NRD*DW-1:0] rd;
   } exp_t;
   exp_t exp_q [$];

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra);
      logic [DW-1:0] v;
      if (rst || !m_ready || ra == '0) return '0;
      v = m_mem[ra];
`ifdef RF_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
         if (s_we[p] && s_wa[p] == ra) v = s_wd[p];
      end
`else
`endif
      return v;
   endfunction

   // One cycle on instance A: drive, predict, push, then advance the model at the edge
   task automatic step();
      exp_t e;
      bit   coll;
      for (int p = 0; p < NWR; p++) begin
         bus_a.wr_en[p]              = s_we[p];
         bus_a.wr_addr[p*AW +: AW]   = s_wa[p];
         bus_a.wr_data[p*DW +: DW]   = s_wd[p];
      end
      for (int r = 0; r < NRD; r++) bus_a.rd_addr[r*AW +: AW] = s_ra[r];
      e.ready   = m_ready;
      e.collide = m_collide;
      for (int r = 0; r < NRD; r++) e.rd[r*DW +: DW] = model_read(s_ra[r]);
      exp_q.push_back(e);
      coll = 1'b0;
      for (int p = 0; p < NWR; p++) begin
         for (int q = p + 1; q < NWR; q++) begin
            if (s_we[p] && s_we[q] && s_wa[p] != '0 && s_wa[p] == s_wa[q]) coll = 1'b1;
         end
      end
      @(posedge clk);
      if (rst) begin
         m_clr_cnt = 0;
         m_ready   = 1'b0;
         m_collide = 1'b0;
      end else if (!m_ready) begin
         m_collide = 1'b0;
         m_clr_cnt++;
         if (m_clr_cnt == NR - 1) begin
            m_ready = 1'b1;
            for (int i = 0; i < NR; i++) m_mem[i] = '0;
         end
      end else begin
         m_collide = coll;
         for (int p = 0; p < NWR; p++) begin
            if (s_we[p] && s_wa[p] != '0) m_mem[s_wa[p]] = s_wd[p];
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      s_we = '0;
      for (int p = 0; p < NWR; p++) begin
         s_wa[p] = '0;
         s_wd[p] = '0;
      end
      for (int r = 0; r < NRD; r++) s_ra[r] = '0;
   endtask

   // Monitor: compare every presented cycle of instance A against the queued prediction
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ready", 64'(bus_a.ready), 64'(e.ready));
            check("wr_collide", 64'(bus_a.wr_collide), 64'(e.collide));
            for (int r = 0; r < NRD; r++) begin
               check($sformatf("rd_data[%0d] addr %0d", r, s_ra[r]),
                     bus_a.rd_data[r*DW +: DW], e.rd[r*DW +: DW]);
            end
         end
      end
   end

   initial begin : stim
      logic [AW_B-1:0] ba [3];
      logic [DW-1:0]   bd [3];
      int              edges;

      rst   = 1'b1;
      rst_b = 1'b1;
      idle_inputs();
      bus_b.wr_en   = '0;
      bus_b.wr_addr = '0;
      bus_b.wr_data = '0;
      bus_b.rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      m_clr_cnt = 0;
      m_ready   = 1'b0;
      m_collide = 1'b0;
      for (int i = 0; i < NR; i++) m_mem[i] = '0;

      // Reset sweep with a write to addr 5 every cycle
      repeat (3) step();
      rst = 1'b0;
      for (int c = 0; c < 36; c++) begin
         s_we[0] = 1'b1;
         s_wa[0] = AW'(5);
         s_wd[0] = 64'hC0DE_0000_0000_0000 | 64'(c);
         s_ra[0] = AW'(5);
         s_ra[1] = AW'($urandom_range(0, NR - 1));
         step();
      end
      idle_inputs();

      // Priority collision on addr 7
      s_we = 2'b11;
      s_wa[0] = AW'(7); s_wd[0] = 64'hAAAA;
      s_wa[1] = AW'(7); s_wd[1] = 64'hBBBB;
      step();
      idle_inputs();
      s_ra[0] = AW'(7);
      s_ra[1] = AW'(7);
      step();
      step();

      // Register 0 writes are dropped and never collide
      s_we = 2'b11;
      s_wa[0] = '0; s_wd[0] = 64'hFFFF;
      s_wa[1] = '0; s_wd[1] = 64'hFFFF;
      step();
      idle_inputs();
      step();
      step();

      // Same-cycle write/read on addr 3
      s_we[0] = 1'b1; s_wa[0] = AW'(3); s_wd[0] = 64'h5555;
      step();
      s_wd[0] = 64'h1234;
      s_ra[0] = AW'(3);
      step();
      s_we = '0;
      step();
      idle_inputs();

      // Random traffic with narrow addresses and occasional reset
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int p = 0; p < NWR; p++) begin
            s_we[p] = 1'($urandom_range(0, 1));
            s_wa[p] = AW'($urandom_range(0, 7));
            s_wd[p] = {$urandom(), $urandom()};
         end
         for (int r = 0; r < NRD; r++) s_ra[r] = AW'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;
      idle_inputs();
      repeat (32) step();

      // Mid-sweep reset: fill, reset, re-reset at pointer 10, then read everything back
      for (int i = 1; i < NR; i++) begin
         s_we[0] = 1'b1; s_wa[0] = AW'(i); s_wd[0] = {$urandom(), $urandom()};
         step();
      end
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (NR - 1) step();
      for (int i = 0; i < NR; i += 2) begin
         s_ra[0] = AW'(i);
         s_ra[1] = AW'(i + 1);
         step();
      end
      idle_inputs();

      // Wide instance: sweep length and 3-port writes readable on all 4 ports
      bus_b.rd_addr = {AW_B'(3), AW_B'(2), AW_B'(1), AW_B'(0)};
      #1;
      check("b_rd_data during reset", bus_b.rd_data[63:0] | bus_b.rd_data[127:64], 64'h0);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      edges = 0;
      while (!bus_b.ready && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("b_sweep_edges", 64'(edges), 64'(NR_B - 1));
      for (int t = 0; t < 12; t++) begin
         ba[0] = AW_B'($urandom_range(1, NR_B - 1));
         do ba[1] = AW_B'($urandom_range(1, NR_B - 1)); while (ba[1] == ba[0]);
         do ba[2] = AW_B'($urandom_range(1, NR_B - 1)); while (ba[2] == ba[0] || ba[2] == ba[1]);
         for (int p = 0; p < 3; p++) begin
            bd[p] = {$urandom(), $urandom()};
            bus_b.wr_addr[p*AW_B +: AW_B] = ba[p];
            bus_b.wr_data[p*DW +: DW]     = bd[p];
         end
         bus_b.wr_en = 3'b111;
         @(posedge clk);
         #1;
         bus_b.wr_en = '0;
         check("b_wr_collide", 64'(bus_b.wr_collide), 64'h0);
         for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < NRD_B; r++) bus_b.rd_addr[r*AW_B +: AW_B] = ba[(r + k) % 3];
            #1;
            for (int r = 0; r < NRD_B; r++) begin
               check($sformatf("b_rd_data[%0d]", r), bus_b.rd_data[r*DW +: DW], bd[(r + k) % 3]);
            end
         end
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file. It succeeds the fixed 2-read/1-write, 64×32 register file in the core's decode/writeback path. It supports a configurable number of read and write ports and deterministic write-port priority. A sequential clear sweep after reset replaces the bulk reset, so reset fan-out stays bounded at larger depths. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- NUM_REGS, 32, register count; power of two, ≥4
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- ADDR_W, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high when the clear sweep is done and writes are accepted
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses
- wr_data  in  NUM_WR*DATA_W  packed write data
- wr_collide  out  1  registered pulse: two or more enabled write ports targeted the same nonzero address in the previous cycle

## Operation
- FSM states: CLEAR, READY.
- On any clk edge with rst=1:
  - state←CLEAR, sweep pointer←1, wr_collide←0.
  - The array is not touched directly; the sweep clears it.
- CLEAR, rst=0:
  - Each edge writes 0 to entry[ptr], then ptr←ptr+1.
  - On the edge where ptr==NUM_REGS-1, that entry is cleared and state←READY.
  - All wr_en are ignored. wr_collide stays 0.
- READY: writes commit on the rising edge.
- Write-port priority: when several enabled ports hit the same address, the highest port index wins.
- Writes to address 0 are discarded. Entry 0 always reads 0.
- wr_collide is computed on enabled ports with nonzero addresses only. It is evaluated in READY only.
- Reads:
  - rd_data[p] = 0 whenever state==CLEAR or rst=1.
  - Otherwise rd_data[p] = entry[rd_addr[p]], subject to the bypass rule in Configuration.
- Reset mid-sweep restarts the sweep from pointer 1.

## Timing
- Reset values: ready=0, wr_collide=0, rd_data=0.
- Sweep length: ready rises on the (NUM_REGS-1)th clk edge after the first edge with rst=0. For defaults this is 31 edges.
- Write latency: 1 edge. The value is visible to non-bypassed reads in the cycle after the commit edge.
- Read latency: 0 cycles (combinational).
- wr_collide is high for exactly the one cycle after the offending cycle.

## Configuration
- RF_BYPASS_EN defined:
  - In READY, a read whose address matches an enabled write port in the same cycle returns that port's wr_data combinationally.
  - When several ports match, the highest-indexed port's data is returned.
  - Address 0 never bypasses.
- RF_BYPASS_EN undefined:
  - Reads return stored array contents only.
  - A same-cycle write is seen on the following cycle.

## Structure
- Shared package reg_file_pkg holds:
  - the state enum type (CLEAR, READY)
  - default parameter constants (DATA_W, NUM_REGS, NUM_RD, NUM_WR)
  - a function that unpacks a port slice from a packed bus
- Sub-module reg_file_wr_arb:
  - Combinational, parametrised by NUM_WR and ADDR_W.
  - Takes wr_en and wr_addr. Outputs a per-port "effective" enable with lower-indexed duplicates masked, plus the collide flag.
  - The same arbitration logic is reused for the bypass select.

## Test plan
- Reset sweep:
  - Stimulus: hold rst 3 cycles, release, then drive wr_en=1 to addr 5 every cycle.
  - Required: ready=0 for 31 edges; all reads are 0; first write commits only after ready=1; after the sweep, register 5 holds the first post-ready data.
- Priority collision:
  - Stimulus: in READY, port0 writes 0xAAAA and port1 writes 0xBBBB, both to addr 7.
  - Required: next cycle rd addr 7 = 0xBBBB and wr_collide=1 for one cycle.
- Register 0:
  - Stimulus: write 0xFFFF to addr 0 on both ports.
  - Required: reads of addr 0 = 0 and wr_collide=0.
- Bypass:
  - Stimulus: write 0x1234 to addr 3 while rd_addr[0]=3 in the same cycle.
  - Required: with RF_BYPASS_EN, same-cycle rd_data[0]=0x1234. Without it, rd_data[0] shows the old value, then 0x1234 next cycle.
- Mid-sweep reset:
  - Stimulus: fill registers 1–31, reset, re-assert rst at sweep pointer 10, then release.
  - Required: ready rises 31 edges after the second release, and every register reads 0.
- Parametric:
  - Stimulus: NUM_REGS=64, NUM_RD=4, NUM_WR=3, each port writing a distinct address.
  - Required: all three values are readable on any of the 4 read ports next cycle, and the sweep takes 63 edges.
